// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
//
// Types and constants shared by the FIR filter and its downstream serial DAC
// stage (dac_serialiser). Keeping the sample type here means both blocks
// always agree on width and signedness.
//
// Contents:
//   SAMPLE_W     width of one filter output sample
//   sample_t     signed filter sample
//   dac_state_t  serialiser frame states
//   halfLsb()    half of one DAC LSB expressed in sample units, used by the
//                optional round-half-up quantiser
// ---------------------------------------------------------------------------
package fir_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // IDLE     : waiting for the hold register to fill
  // SHIFT_LO : sclk low half of a bit, data presented
  // SHIFT_HI : sclk high half of a bit, DAC samples on the rising edge
  // GAP      : one idle cycle with sync_n high between frames
  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    GAP
  } dac_state_t;

  // Half an output LSB in sample units. At full 16-bit resolution there is
  // nothing below the LSB to round, so the offset collapses to zero instead
  // of a negative shift.
  function automatic int halfLsb(input int dacBits);
    if (dacBits < SAMPLE_W) begin
      return 1 << (SAMPLE_W - 1 - dacBits);
    end
    return 0;
  endfunction

endpackage

// File: rtl/dac_quantise.sv
// ---------------------------------------------------------------------------
// dac_quantise
//
// Purely combinational quantiser: reduces a signed 16-bit filter sample to a
// DAC_BITS-wide offset-binary code (two's complement with the MSB inverted,
// so the most negative sample maps to all-zeros and the most positive to
// all-ones).
//
// Build option:
//   DAC_SERIALISER_ROUND_EN  defined   -> round half-up, saturating at the
//                                         positive rail, then truncate
//                            undefined -> plain truncation (floor)
//
// Parameters:
//   DAC_BITS  converter resolution, 2..16
//
// Ports:
//   sample_i  in   16        signed sample
//   code_o    out  DAC_BITS  offset-binary code
// ---------------------------------------------------------------------------
module dac_quantise
  import fir_pkg::*;
#(
  parameter int DAC_BITS = 12
) (
  input  sample_t             sample_i,
  output logic [DAC_BITS-1:0] code_o
);

  sample_t rounded;

`ifdef DAC_SERIALISER_ROUND_EN
  localparam logic [SAMPLE_W:0] HALF_LSB = (SAMPLE_W + 1)'(halfLsb(DAC_BITS));

  logic [SAMPLE_W:0] sum;

  // The adder is one bit wider than the sample so that a positive overflow
  // shows up as bits [16:15] = 01; a negative overflow cannot happen because
  // the rounding offset is never negative.
  assign sum = {sample_i[SAMPLE_W-1], sample_i} + HALF_LSB;

  // Clamp to the largest positive sample rather than letting the code wrap
  // round to the bottom of the converter range.
  always_comb begin
    rounded = sample_t'(sum[SAMPLE_W-1:0]);
    if (sum[SAMPLE_W:SAMPLE_W-1] == 2'b01) begin
      rounded = sample_t'(16'h7FFF);
    end
  end
`else
  // Truncation keeps the top bits as they are, which floors toward minus
  // infinity for two's-complement samples.
  always_comb begin
    rounded = sample_i;
  end
`endif

  // Take the top DAC_BITS bits and flip the sign bit to get offset binary.
  assign code_o = {~rounded[SAMPLE_W-1], rounded[SAMPLE_W-2 -: DAC_BITS-1]};

  // Bits below the DAC resolution are deliberately discarded.
  logic unusedLowBits;
  assign unusedLowBits = ^rounded;

endmodule

// File: rtl/dac_serialiser.sv
// ---------------------------------------------------------------------------
// dac_serialiser
//
// Downstream stage of the FIR filter. Each rising edge of input_ready
// captures the current sample, quantises it to DAC_BITS offset binary, and
// shifts it MSB-first onto a 3-wire serial DAC (sclk, sync_n, sdata).
//
// A one-entry hold register decouples the sample strobe from the frame in
// flight: a sample arriving mid-frame waits there until the frame ends. If a
// second sample arrives while the hold register is still full, it replaces
// the older one and the sticky overrun flag is raised.
//
// Timing (HALF_PERIOD = H):
//   accept edge N -> hold loaded at N, frame loaded at N+1, sync_n low and
//   first bit on sdata from edge N+2; sync_n stays low for 2*DAC_BITS*H
//   cycles, then is high for at least two cycles (GAP + IDLE).
//
// Build option:
//   DAC_SERIALISER_ROUND_EN  selects round-half-up instead of truncation in
//                            the quantiser (see dac_quantise).
//
// Parameters:
//   DAC_BITS     converter resolution, 2..16
//   HALF_PERIOD  ck cycles per sclk half-period, >= 1
//
// Ports:
//   ck           in   1   system clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   in           in   16  signed sample from the FIR output
//   input_ready  in   1   sample strobe, rising edge significant
//   sclk         out  1   serial clock, idles low
//   sync_n       out  1   frame select, active low
//   sdata        out  1   serial data, MSB first
//   busy         out  1   frame in progress or sample pending
//   overrun      out  1   sticky: a pending sample was overwritten
// ---------------------------------------------------------------------------
module dac_serialiser
  import fir_pkg::*;
#(
  parameter int DAC_BITS    = 12,
  parameter int HALF_PERIOD = 1
) (
  input  logic    ck,
  input  logic    rst,
  input  sample_t in,
  input  logic    input_ready,
  output logic    sclk,
  output logic    sync_n,
  output logic    sdata,
  output logic    busy,
  output logic    overrun
);

  localparam int CNT_W  = $clog2(DAC_BITS);
  localparam int HALF_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DAC_BITS - 1);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(HALF_PERIOD - 1);

  // Strobe edge detection
  logic prevReady_q;
  logic accept;

  // Hold register
  logic [DAC_BITS-1:0] code;
  logic [DAC_BITS-1:0] holdCode_q, holdCode_d;
  logic                holdValid_q, holdValid_d;
  logic                overrun_q, overrun_d;

  // Frame FSM and datapath
  dac_state_t          state_q;
  logic [DAC_BITS-1:0] shift_q;
  logic [CNT_W-1:0]    bitCnt_q;
  logic [HALF_W-1:0]   halfCnt_q;
  logic                sclk_q, syncN_q, sdata_q;
  logic                load;
  logic                halfDone;

  dac_quantise #(
    .DAC_BITS (DAC_BITS)
  ) u_quantise (
    .sample_i (in),
    .code_o   (code)
  );

  // A strobe that stays high for several cycles should only be counted once,
  // so we act on the low-to-high transition of input_ready.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      prevReady_q <= 1'b0;
    end else begin
      prevReady_q <= input_ready;
    end
  end

  assign accept = input_ready & ~prevReady_q;

  // The frame FSM empties the hold register whenever it starts a frame.
  assign load     = (state_q == IDLE) && holdValid_q;
  assign halfDone = (halfCnt_q == LAST_HALF);

  // Hold-register next state. A new sample always wins; it only counts as an
  // overrun if the previous one is still waiting and is not being moved into
  // the shift register on this very cycle.
  always_comb begin
    holdCode_d  = holdCode_q;
    holdValid_d = holdValid_q;
    overrun_d   = overrun_q;
    if (load) begin
      holdValid_d = 1'b0;
    end
    if (accept) begin
      holdCode_d  = code;
      holdValid_d = 1'b1;
      if (holdValid_q && !load) begin
        overrun_d = 1'b1;
      end
    end
  end

  // Hold register and sticky overrun flag; overrun only clears on reset.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      holdCode_q  <= '0;
      holdValid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      holdCode_q  <= holdCode_d;
      holdValid_q <= holdValid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Frame FSM. The pin registers are driven from the state held during the
  // current cycle, so the pins trail the state by one clock; this is what
  // puts the first bit two edges after the accepting edge. sdata is taken
  // from the shift register before it moves, so it is stable for the whole
  // high half of sclk where the DAC samples it.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      halfCnt_q <= '0;
      sclk_q    <= 1'b0;
      syncN_q   <= 1'b1;
      sdata_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sclk_q  <= 1'b0;
          syncN_q <= 1'b1;
          sdata_q <= 1'b0;
          if (holdValid_q) begin
            shift_q   <= holdCode_q;
            bitCnt_q  <= LAST_BIT;
            halfCnt_q <= '0;
            state_q   <= SHIFT_LO;
          end
        end

        SHIFT_LO: begin
          sclk_q  <= 1'b0;
          syncN_q <= 1'b0;
          sdata_q <= shift_q[DAC_BITS-1];
          if (halfDone) begin
            halfCnt_q <= '0;
            state_q   <= SHIFT_HI;
          end else begin
            halfCnt_q <= halfCnt_q + HALF_W'(1);
          end
        end

        SHIFT_HI: begin
          sclk_q  <= 1'b1;
          syncN_q <= 1'b0;
          sdata_q <= shift_q[DAC_BITS-1];
          if (halfDone) begin
            halfCnt_q <= '0;
            if (bitCnt_q == '0) begin
              state_q <= GAP;
            end else begin
              shift_q  <= {shift_q[DAC_BITS-2:0], 1'b0};
              bitCnt_q <= bitCnt_q - CNT_W'(1);
              state_q  <= SHIFT_LO;
            end
          end else begin
            halfCnt_q <= halfCnt_q + HALF_W'(1);
          end
        end

        GAP: begin
          sclk_q  <= 1'b0;
          syncN_q <= 1'b1;
          sdata_q <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          sclk_q  <= 1'b0;
          syncN_q <= 1'b1;
          sdata_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sclk    = sclk_q;
  assign sync_n  = syncN_q;
  assign sdata   = sdata_q;
  assign overrun = overrun_q;

  // busy covers both a frame in flight and a sample waiting in the hold
  // register, so upstream can tell when the serialiser is fully drained.
  assign busy = (state_q != IDLE) | holdValid_q;

endmodule
